// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential signed restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH) + 1;
  // Magnitude helper works at this fixed width; callers sign-extend into it.
  localparam int ABS_W     = 64;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  function automatic logic [ABS_W-1:0] abs_u(input logic signed [ABS_W-1:0] v);
    logic [ABS_W-1:0] u;
    u = v;
    return v[ABS_W-1] ? -u : u;
  endfunction

endpackage

// File: rtl/seq_div_stage.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract dsr.
module seq_div_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             trial_neg;
  // The partial remainder stays below dsr, so its top bit is always clear before the shift.
  logic             unused_rem_msb;

  assign unused_rem_msb = rem[WIDTH];
  assign rem_sh         = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign trial          = {1'b0, rem_sh} - {2'b00, dsr};
  assign trial_neg      = trial[WIDTH+1];

  always_comb begin
    rem_next = rem_sh;
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!trial_neg) begin
      rem_next = trial[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider, one quotient bit per cycle, C-style truncation.
// Optional divide-by-zero short-cut enabled by defining SEQ_DIV_ZERO_DET_EN.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic signed [WIDTH-1:0] quotient,
  output logic signed [WIDTH-1:0] remainder,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t state, state_next;

  logic signed [WIDTH-1:0] dvd_reg;
  logic signed [WIDTH-1:0] dvs_reg;
  logic [WIDTH:0]          rem_reg;
  logic [WIDTH-1:0]        quo_reg;
  logic [WIDTH-1:0]        dsr_reg;
  logic [CW-1:0]           cnt;
  logic                    sd;
  logic                    sv;

  logic [WIDTH:0]          rem_step;
  logic [WIDTH-1:0]        quo_step;
  logic [ABS_W-1:0]        dvd_abs;
  logic [ABS_W-1:0]        dvs_abs;
  logic                    unused_abs_hi;

  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  assign dvd_abs = abs_u({{(ABS_W-WIDTH){dvd_reg[WIDTH-1]}}, dvd_reg});
  assign dvs_abs = abs_u({{(ABS_W-WIDTH){dvs_reg[WIDTH-1]}}, dvs_reg});
  assign unused_abs_hi = ^{dvd_abs[ABS_W-1:WIDTH], dvs_abs[ABS_W-1:WIDTH]};

  seq_div_stage #(
    .WIDTH (WIDTH)
  ) u_stage (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .dsr      (dsr_reg),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

`ifdef SEQ_DIV_ZERO_DET_EN
  logic dz;
  logic dbz_reg;
  assign div_by_zero = dbz_reg;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        state_next = ITER;
`ifdef SEQ_DIV_ZERO_DET_EN
        if (dvs_reg == '0) state_next = FIX;
`endif
      end
      ITER: if (cnt == CW'(WIDTH - 1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dsr_reg   <= '0;
      cnt       <= '0;
      sd        <= 1'b0;
      sv        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_DIV_ZERO_DET_EN
      dz        <= 1'b0;
      dbz_reg   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_reg <= dividend;
            dvs_reg <= divisor;
            busy    <= 1'b1;
          end
        end
        // Magnitudes are unsigned, so the most negative operand needs no special case.
        LOAD: begin
          sd      <= dvd_reg[WIDTH-1];
          sv      <= dvs_reg[WIDTH-1];
          quo_reg <= dvd_abs[WIDTH-1:0];
          dsr_reg <= dvs_abs[WIDTH-1:0];
          rem_reg <= '0;
          cnt     <= '0;
`ifdef SEQ_DIV_ZERO_DET_EN
          dz      <= (dvs_reg == '0);
`endif
        end
        ITER: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          cnt     <= cnt + CW'(1);
        end
        FIX: begin
`ifdef SEQ_DIV_ZERO_DET_EN
          dbz_reg <= dz;
          if (dz) begin
            quotient  <= '1;
            remainder <= dvd_reg;
          end else
`endif
          begin
            quotient  <= neg_if(sd ^ sv, quo_reg);
            remainder <= neg_if(sd, rem_reg[WIDTH-1:0]);
          end
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8) against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 8;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic signed [W-1:0] dividend;
  logic signed [W-1:0] divisor;
  logic signed [W-1:0] quotient;
  logic signed [W-1:0] remainder;
  logic                busy;
  logic                done;
  logic                div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: C semantics for nonzero divisors, documented result for zero.
  task automatic model(input int a, input int b, output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output int lat);
    if (b == 0) begin
`ifdef SEQ_DIV_ZERO_DET_EN
      q = '1; r = W'(a); dz = 1'b1; lat = 2;
`else
      q = (a < 0) ? W'(-((1 << W) - 1)) : W'((1 << W) - 1);
      r = W'(a); dz = 1'b0; lat = W + 2;
`endif
    end else begin
      q = W'(a / b); r = W'(a % b); dz = 1'b0; lat = W + 2;
    end
  endtask

  task automatic run_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_q got %0h want 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_r got %0h want 0", remainder); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctl got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] q, r; logic dz; int lat;
    run_op(8'sd100, 8'sd7, q, r, dz, lat);
    checks++; if (q !== 8'd14) begin errors++; $display("FAIL basic_q got %0d want 14", $signed(q)); end
    checks++; if (r !== 8'd2) begin errors++; $display("FAIL basic_r got %0d want 2", $signed(r)); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL basic_latency got %0d want 10", lat); end
  endtask

  task automatic test_signs();
    int ta[3] = '{-100, 100, -100};
    int tb[3] = '{7, -7, -7};
    int tq[3] = '{-14, -14, 14};
    int tr[3] = '{-2, 2, -2};
    logic [W-1:0] q, r; logic dz; int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(W'(ta[i]), W'(tb[i]), q, r, dz, lat);
      checks++;
      if (q !== W'(tq[i]) || r !== W'(tr[i])) begin
        errors++;
        $display("FAIL signs_%0d got q=%0d r=%0d want q=%0d r=%0d", i, $signed(q), $signed(r), tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_boundary();
    int ta[3] = '{-128, -128, 5};
    int tb[3] = '{-1, 3, 9};
    int tq[3] = '{-128, -42, 0};
    int tr[3] = '{0, -2, 5};
    logic [W-1:0] q, r; logic dz; int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(W'(ta[i]), W'(tb[i]), q, r, dz, lat);
      checks++;
      if (q !== W'(tq[i]) || r !== W'(tr[i]) || lat !== 10) begin
        errors++;
        $display("FAIL boundary_%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=10",
                 i, $signed(q), $signed(r), lat, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r; logic dz; int lat;
    logic exp_dz; int exp_lat;
`ifdef SEQ_DIV_ZERO_DET_EN
    exp_dz = 1'b1; exp_lat = 2;
`else
    exp_dz = 1'b0; exp_lat = 10;
`endif
    run_op(8'sd37, 8'sd0, q, r, dz, lat);
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL dz_q got %0h want ff", q); end
    checks++; if (r !== 8'd37) begin errors++; $display("FAIL dz_r got %0d want 37", $signed(r)); end
    checks++; if (dz !== exp_dz) begin errors++; $display("FAIL dz_flag got %b want %b", dz, exp_dz); end
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL dz_latency got %0d want %0d", lat, exp_lat); end
  endtask

  task automatic test_start_while_busy();
    int dones = 0; int first = -1; int busy_bad = 0;
    logic [W-1:0] q, r;
    @(negedge clk);
    dividend = 8'sd100; divisor = 8'sd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 4) begin
        dividend = 8'sd50; divisor = 8'sd5; start = 1'b1;
      end
      @(posedge clk);
      #1;
      if (k == 4) start = 1'b0;
      if (k < 10 && busy !== 1'b1) busy_bad++;
      if (done) begin
        dones++;
        if (first < 0) begin first = k; q = quotient; r = remainder; end
      end
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", dones); end
    checks++; if (first !== 10) begin errors++; $display("FAIL busy_latency got %0d want 10", first); end
    checks++; if (q !== 8'd14 || r !== 8'd2) begin errors++; $display("FAIL busy_result got q=%0d r=%0d want q=14 r=2", $signed(q), $signed(r)); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL busy_level got %0d low cycles want 0", busy_bad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle_end got %b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] q, r; logic dz; int lat;
    @(negedge clk);
    dividend = 8'sd100; divisor = 8'sd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (quotient !== '0 || remainder !== '0) begin errors++; $display("FAIL midreset_out got q=%0h r=%0h want 0 0", quotient, remainder); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_ctl got busy=%b done=%b want 0 0", busy, done); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'sd50, 8'sd5, q, r, dz, lat);
    checks++; if (q !== 8'd10 || r !== 8'd0 || lat !== 10) begin
      errors++; $display("FAIL midreset_after got q=%0d r=%0d lat=%0d want q=10 r=0 lat=10", $signed(q), $signed(r), lat);
    end
  endtask

  task automatic test_random();
    logic signed [W-1:0] a, b;
    logic [W-1:0] q, r, eq, er; logic dz, edz; int lat, elat;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 15) == 0) a = 8'sh80;
      if ($urandom_range(0, 15) == 0) b = 8'shFF;
      if (b == 0) b = 8'sd1;
      model(int'(a), int'(b), eq, er, edz, elat);
      run_op(a, b, q, r, dz, lat);
      checks++;
      if (q !== eq || r !== er || dz !== edz || lat !== elat) begin
        errors++;
        $display("FAIL random_%0d %0d/%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=%0d",
                 i, a, b, $signed(q), $signed(r), lat, $signed(eq), $signed(er), elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_boundary();
    test_div_zero();
    test_start_while_busy();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
